// File: rtl/pmem_model_pkg.sv
// pmem_model_pkg: shared FSM state type and default parameters for the line memory model
package pmem_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int          DEF_LINE_WIDTH = 256;
    localparam int          DEF_DEPTH      = 1024;
    localparam int          DEF_LATENCY    = 10;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h4000_0000;

endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: DEPTH x LINE_WIDTH line store, one synchronous write port, one combinational read port
module pmem_line_array
    import pmem_model_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [LINE_WIDTH-1:0] o_rdata
);

    // contents survive reset; they only start out as zeros at power-up
    logic [LINE_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    // line write on the rising edge
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pmem_line_model.sv
// pmem_line_model: fixed-latency line-granular memory model with range and protocol error flags
module pmem_line_model
    import pmem_model_pkg::*;
#(
    parameter int          LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int          DEPTH      = DEF_DEPTH,
    parameter int          LATENCY    = DEF_LATENCY,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  busy,
    output logic                  err_oor,
    output logic                  err_proto
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          OB   = $clog2(LINE_WIDTH / 8);
    localparam int          CW   = $clog2(LATENCY + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(LINE_WIDTH / 8);

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_wr;
    logic [31:0]           r_addr;
    logic [LINE_WIDTH-1:0] r_wdata, r_rdata;
    logic                  r_err_oor, r_err_proto;

    logic                  w_accept, w_both, w_to_resp, w_e_wr, w_in_range, w_we, w_proto_wait;
    logic [31:0]           w_e_addr, w_off;
    logic [LINE_WIDTH-1:0] w_e_wdata, w_line;
    logic [AW-1:0]         w_idx;

    // with LATENCY 1 the response is entered straight from IDLE, so the
    // live request stands in for the not-yet-latched one
    always_comb begin
        w_accept     = pmem_read ^ pmem_write;
        w_both       = pmem_read & pmem_write;
        w_e_addr     = (r_state == ST_IDLE) ? pmem_address : r_addr;
        w_e_wr       = (r_state == ST_IDLE) ? pmem_write : r_wr;
        w_e_wdata    = (r_state == ST_IDLE) ? pmem_wdata : r_wdata;
        w_off        = w_e_addr - BASE_ADDR;
        w_in_range   = (w_e_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
        w_idx        = AW'(w_off >> OB);
        w_proto_wait = (r_state == ST_WAIT) &&
                       (({pmem_read, pmem_write} != {~r_wr, r_wr}) || (pmem_address != r_addr));
        w_to_resp    = (w_next == ST_RESP);
        w_we         = w_to_resp && w_e_wr && w_in_range && !rst;
    end

    pmem_line_array #(
        .LINE_WIDTH (LINE_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (w_e_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_line)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // next state: a single clean request starts a transaction, RESP always lasts one cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: w_next = !w_accept ? ST_IDLE : (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: w_next = (r_cnt == CW'(LATENCY)) ? ST_RESP : ST_WAIT;
            default: w_next = ST_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        pmem_resp  = (r_state == ST_RESP);
        busy       = (r_state != ST_IDLE);
        pmem_rdata = r_rdata;
        err_oor    = r_err_oor;
        err_proto  = r_err_proto;
    end

    // request latch, latency counter, read data and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err_oor   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_wr    <= pmem_write;
                r_addr  <= pmem_address;
                r_wdata <= pmem_wdata;
            end
            r_cnt <= (r_state == ST_IDLE && w_accept) ? CW'(1) :
                     (r_state == ST_WAIT && !w_to_resp) ? r_cnt + 1'b1 : '0;
            if ((r_state == ST_IDLE && w_both) || w_proto_wait) r_err_proto <= 1'b1;
            if (w_to_resp && !w_in_range) r_err_oor <= 1'b1;
            if (w_to_resp && !w_e_wr) r_rdata <= w_in_range ? w_line : '0;
        end
    end

endmodule

// File: tb/tb_pmem_line_model.sv
// tb_pmem_line_model: scoreboard bench for the line memory model at LATENCY 10 and LATENCY 1
module tb_pmem_line_model;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] TOP  = 32'h4001_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0, addr1 = '0;
    logic         rd = 1'b0, wr = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [255:0] wdata = '0, wdata1 = '0;
    logic [255:0] rdata, rdata1;
    logic         resp, resp1, busy, busy1, oor, oor1, proto, proto1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] exp_q [$];
    logic [255:0] mdl [int unsigned];

    always #5 clk = ~clk;

    pmem_line_model #(.DEPTH(2048)) dut (
        .clk (clk), .rst (rst), .pmem_address (addr), .pmem_read (rd), .pmem_write (wr),
        .pmem_wdata (wdata), .pmem_rdata (rdata), .pmem_resp (resp), .busy (busy),
        .err_oor (oor), .err_proto (proto)
    );

    pmem_line_model #(.LATENCY(1)) dut1 (
        .clk (clk), .rst (rst), .pmem_address (addr1), .pmem_read (rd1), .pmem_write (wr1),
        .pmem_wdata (wdata1), .pmem_rdata (rdata1), .pmem_resp (resp1), .busy (busy1),
        .err_oor (oor1), .err_proto (proto1)
    );

    function automatic bit in_rng(input logic [31:0] a);
        return a >= BASE && a < TOP;
    endfunction

    function automatic logic [255:0] mdl_rd(input logic [31:0] a);
        int unsigned k;
        k = (a - BASE) >> 5;
        if (!in_rng(a) || !mdl.exists(k)) return '0;
        return mdl[k];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic txn(input bit w, input logic [31:0] a, input logic [255:0] d, input bit glitch, input string nm);
        logic [255:0] e;
        int j;
        @(negedge clk);
        rd = !w; wr = w; addr = a; wdata = d;
        if (!w) exp_q.push_back(mdl_rd(a));
        j = 0;
        @(negedge clk);
        n_cmp++;
        if (resp !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s accept: resp=%b busy=%b, want resp=0 busy=1", nm, resp, busy);
        end
        while (resp !== 1'b1 && j < 40) begin
            if (glitch && j == 3) addr = a + 32'h20;
            @(negedge clk);
            j++;
        end
        n_cmp++;
        if (j != 10) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, want 10", nm, j);
        end
        if (!w) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rdata !== e) begin
                n_bad++;
                $display("FAIL %s rdata: got %0h want %0h", nm, rdata, e);
            end
        end else if (in_rng(a)) begin
            mdl[(a - BASE) >> 5] = d;
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (resp !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release: resp=%b busy=%b, want 0 0", nm, resp, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({resp, busy, oor, proto} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset flags: resp/busy/oor/proto=%b want 0000", {resp, busy, oor, proto});
        end
        n_cmp++;
        if (rdata !== '0) begin
            n_bad++;
            $display("FAIL reset rdata: got %0h want 0", rdata);
        end
        n_cmp++;
        if ({resp1, busy1, oor1, proto1} !== 4'b0 || rdata1 !== '0) begin
            n_bad++;
            $display("FAIL reset dut1: flags=%b rdata=%0h want 0", {resp1, busy1, oor1, proto1}, rdata1);
        end
    endtask

    task automatic test_write_read();
        txn(1'b1, 32'h4000_8000, 256'h1234, 1'b0, "wr_8000");
        txn(1'b0, 32'h4000_8000, '0, 1'b0, "rd_8000");
        txn(1'b0, 32'h4000_801F, '0, 1'b0, "rd_8000_offset");
        txn(1'b1, 32'h4000_FFE0, 256'hBEEF, 1'b0, "wr_last");
        txn(1'b0, 32'h4000_FFE0, '0, 1'b0, "rd_last");
        txn(1'b0, 32'h4000_7FE0, '0, 1'b0, "rd_unwritten");
        n_cmp++;
        if (oor !== 1'b0 || proto !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rd flags: oor=%b proto=%b want 0 0", oor, proto);
        end
    endtask

    task automatic test_lat1();
        logic [255:0] e;
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h4000_0020;
        exp_q.push_back('0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (resp1 !== 1'b1 || busy1 !== 1'b1 || rdata1 !== e) begin
            n_bad++;
            $display("FAIL lat1 read: resp=%b busy=%b rdata=%0h want 1 1 %0h", resp1, busy1, rdata1, e);
        end
        rd1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (resp1 !== 1'b0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1 release: resp=%b busy=%b want 0 0", resp1, busy1);
        end
        wr1 = 1'b1; wdata1 = 256'h55;
        @(negedge clk);
        n_cmp++;
        if (resp1 !== 1'b1) begin
            n_bad++;
            $display("FAIL lat1 write resp: got %b want 1", resp1);
        end
        wr1 = 1'b0;
        @(negedge clk);
        rd1 = 1'b1;
        exp_q.push_back(256'h55);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (resp1 !== 1'b1 || rdata1 !== e) begin
            n_bad++;
            $display("FAIL lat1 readback: resp=%b rdata=%0h want 1 %0h", resp1, rdata1, e);
        end
        rd1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oor();
        txn(1'b0, 32'h3FFF_FFE0, '0, 1'b0, "rd_below");
        n_cmp++;
        if (oor !== 1'b1) begin
            n_bad++;
            $display("FAIL oor flag: got %b want 1", oor);
        end
        txn(1'b1, 32'h4000_0000, 256'hCAFE, 1'b0, "wr_line0");
        txn(1'b1, TOP, 256'hDEAD, 1'b0, "wr_top");
        txn(1'b0, 32'h4000_0000, '0, 1'b0, "rd_line0");
        txn(1'b0, TOP, '0, 1'b0, "rd_top");
        n_cmp++;
        if (oor !== 1'b1 || proto !== 1'b0) begin
            n_bad++;
            $display("FAIL oor sticky: oor=%b proto=%b want 1 0", oor, proto);
        end
    endtask

    task automatic test_proto();
        do_reset();
        n_cmp++;
        if (oor !== 1'b0) begin
            n_bad++;
            $display("FAIL oor cleared: got %b want 0", oor);
        end
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = BASE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL both_req cycle %0d: resp=%b busy=%b want 0 0", i, resp, busy);
            end
        end
        n_cmp++;
        if (proto !== 1'b1) begin
            n_bad++;
            $display("FAIL both_req proto: got %b want 1", proto);
        end
        rd = 1'b0; wr = 1'b0;
        do_reset();
        txn(1'b1, 32'h4000_0100, 256'h77, 1'b1, "wr_glitch");
        n_cmp++;
        if (proto !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch proto: got %b want 1", proto);
        end
        txn(1'b0, 32'h4000_0100, '0, 1'b0, "rd_glitch_orig");
        txn(1'b0, 32'h4000_0120, '0, 1'b0, "rd_glitch_moved");
    endtask

    task automatic test_reset_mid();
        int nr;
        do_reset();
        @(negedge clk);
        wr = 1'b1; addr = 32'h4000_0040; wdata = 256'hABCD;
        repeat (5) @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || resp !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid state: busy=%b resp=%b want 0 0", busy, resp);
        end
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp === 1'b1) nr++;
        end
        n_cmp++;
        if (nr != 0) begin
            n_bad++;
            $display("FAIL rst_mid resp: got %0d pulses want 0", nr);
        end
        txn(1'b0, 32'h4000_0040, '0, 1'b0, "rd_after_abort");
    endtask

    task automatic test_back_to_back();
        int nr, t1, t2;
        logic [255:0] e;
        do_reset();
        nr = 0; t1 = -1; t2 = -1;
        @(negedge clk);
        rd = 1'b1; addr = 32'h4000_8000;
        exp_q.push_back(mdl_rd(addr));
        exp_q.push_back(mdl_rd(addr));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                nr++;
                if (nr == 1) t1 = i;
                else t2 = i;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (rdata !== e) begin
                        n_bad++;
                        $display("FAIL b2b rdata %0d: got %0h want %0h", nr, rdata, e);
                    end
                end
            end
            if (i == 22) rd = 1'b0;
        end
        n_cmp++;
        if (nr != 2 || t1 != 10 || t2 != 22) begin
            n_bad++;
            $display("FAIL b2b timing: pulses=%0d at %0d,%0d want 2 at 10,22", nr, t1, t2);
        end
        n_cmp++;
        if (proto !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b flags: proto=%b busy=%b want 0 0", proto, busy);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_lat1();
        test_oor();
        test_proto();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
